conv3x3_pixel_source: RTL and testbench

- Upstream pixel source for the VGA output stage. Answers each pixel request (x, y) with a 4-bit grayscale value.
- The value is a 3x3 convolution of a grayscale image held in an external synchronous-read frame memory.
- Keeps a sliding 3-column window, so each request costs three memory reads.
- Selects one of four kernels at runtime.

---
 rtl/conv3x3_pixel_source.sv | 244 ++++++++++++++++++++++++
 tb/tb_conv3x3_pixel_source.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv3x3_pixel_source.sv
// conv3x3_pixel_source
//   Upstream pixel source for the VGA output stage. Each pixel request (x, y)
//   is answered with a 4-bit grayscale value: a 3x3 convolution over an
//   external frame memory (address = y*IMG_W + x). A sliding 3-column window
//   means each request costs three memory reads (column x+1, rows y-1..y+1).
//
// Ports
//   clk             system clock
//   reset           synchronous reset, active low
//   pixel_request   one-cycle request strobe (>= 4 cycles apart)
//   pixel_x/_y      requested column / row
//   kernel_sel      0 identity, 1 box blur, 2 laplacian edge, 3 sharpen
//   threshold       (CONV_THRESHOLD_EN only) binarisation level
//   mem_rd_en       frame memory read enable (registered)
//   mem_addr        frame memory read address (registered)
//   mem_rd_data     read data, valid on the edge after mem_rd_en
//   grayscale_pixel result for the last accepted request
//   busy            fetch in progress
//   overrun         sticky: request arrived while busy
//   sync_err        sticky: column 0 requested without a matching line prime
//
// Build option
//   CONV_THRESHOLD_EN  adds the threshold input; in-image results become 15/0.
//
// state  | meaning
// IDLE   | waiting for a request
// RD_TOP | read slot for row y-1 of the fetch column
// RD_MID | read slot for row y
// RD_BOT | read slot for row y+1; result registered on exit
module conv3x3_pixel_source #(
  parameter int IMG_W  = 640,
  parameter int IMG_H  = 480,
  parameter int H_LAST = 799,
  parameter int V_LAST = 524,
  parameter int ADDR_W = 19
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pixel_request,
  input  logic [9:0]        pixel_x,
  input  logic [9:0]        pixel_y,
  input  logic [1:0]        kernel_sel,
`ifdef CONV_THRESHOLD_EN
  input  logic [3:0]        threshold,
`endif
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [3:0]        mem_rd_data,
  output logic [3:0]        grayscale_pixel,
  output logic              busy,
  output logic              overrun,
  output logic              sync_err
);
  typedef enum logic [1:0] {IDLE, RD_TOP, RD_MID, RD_BOT} state_t;

  localparam logic [9:0]        IMG_W_C  = 10'(IMG_W);
  localparam logic [10:0]       IMG_H_C  = 11'(IMG_H);
  localparam logic [9:0]        H_LAST_C = 10'(H_LAST);
  localparam logic [9:0]        V_LAST_C = 10'(V_LAST);
  localparam logic [ADDR_W-1:0] IMG_W_A  = ADDR_W'(IMG_W);

  state_t state_q, state_d;
  // window [column L,C,R][row top,mid,bot]
  logic [2:0][2:0][3:0] win_q, win_d, wk;
  logic [9:0]  fx_q, fx_d, fy_q, fy_d;
  logic [1:0]  kern_q, kern_d;
  logic        prime_q, prime_d, zpend_q, zpend_d;
  logic        primed_vld_q, primed_vld_d;
  logic [9:0]  primed_row_q, primed_row_d;
  logic [3:0]  gray_q, gray_d;
  logic        rd_en_q, rd_en_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic        overrun_q, overrun_d, sync_err_q, sync_err_d;
`ifdef CONV_THRESHOLD_EN
  logic [3:0]  thr_q, thr_d;
`endif

  logic        in_img;
  logic [9:0]  prime_row;
  logic [3:0]  rd_val, centre, k_res, out_res;
  logic [7:0]  sum9, n8, n4;
  logic [12:0] box_prod;
  logic signed [8:0] lap, sharp;
  logic [8:0]  lap_mag;
  logic [1:0]  slot;
  logic [10:0] row_p1;   // target row + 1, so row -1 maps to 0

  // border slots keep mem_rd_en low; their window entry reads as zero
  assign rd_val    = rd_en_q ? mem_rd_data : 4'd0;
  assign in_img    = (pixel_x < IMG_W_C) && ({1'b0, pixel_y} < IMG_H_C);
  assign prime_row = (pixel_y == V_LAST_C) ? 10'd0 : pixel_y + 10'd1;

  // kernel over the window with the bottom-right entry taken straight from memory
  always_comb begin
    wk = win_q;
    wk[2][2] = rd_val;
    sum9 = 8'd0;
    for (int c = 0; c < 3; c++)
      for (int r = 0; r < 3; r++)
        sum9 = sum9 + 8'(wk[c][r]);
    centre   = wk[1][1];
    n8       = sum9 - 8'(centre);
    n4       = 8'(wk[1][0]) + 8'(wk[1][2]) + 8'(wk[0][1]) + 8'(wk[2][1]);
    box_prod = 13'(sum9) * 13'd57;
    lap      = $signed({2'b00, centre, 3'b000}) - $signed({1'b0, n8});
    lap_mag  = lap[8] ? 9'(-lap) : 9'(lap);
    sharp    = $signed(9'({centre, 2'b00}) + 9'(centre)) - $signed({1'b0, n4});
    case (kern_q)
      2'd0:    k_res = centre;
      2'd1:    k_res = 4'(box_prod >> 9);
      2'd2:    k_res = (lap_mag > 9'd15) ? 4'd15 : 4'(lap_mag);
      default: k_res = sharp[8] ? 4'd0 : ((sharp > 9'sd15) ? 4'd15 : 4'(sharp));
    endcase
`ifdef CONV_THRESHOLD_EN
    out_res = (k_res >= thr_q) ? 4'd15 : 4'd0;
`else
    out_res = k_res;
`endif
  end

  always_comb begin
    state_d      = state_q;
    win_d        = win_q;
    fx_d         = fx_q;
    fy_d         = fy_q;
    kern_d       = kern_q;
    prime_d      = prime_q;
    zpend_d      = 1'b0;
    primed_vld_d = primed_vld_q;
    primed_row_d = primed_row_q;
    gray_d       = zpend_q ? 4'd0 : gray_q;
    overrun_d    = overrun_q | (pixel_request & (state_q != IDLE));
    sync_err_d   = sync_err_q;
`ifdef CONV_THRESHOLD_EN
    thr_d        = thr_q;
`endif
    case (state_q)
      IDLE: if (pixel_request) begin
        kern_d = kernel_sel;
`ifdef CONV_THRESHOLD_EN
        thr_d  = threshold;
`endif
        if (in_img) begin
          if (pixel_x == 10'd0 && !(primed_vld_q && primed_row_q == pixel_y)) begin
            sync_err_d = 1'b1;
            zpend_d    = 1'b1;
          end else begin
            state_d  = RD_TOP;
            fx_d     = pixel_x + 10'd1;
            fy_d     = pixel_y;
            prime_d  = 1'b0;
            win_d[0] = win_q[1];
            win_d[1] = win_q[2];
          end
        end else if (pixel_x == H_LAST_C) begin
          primed_vld_d = 1'b1;
          primed_row_d = prime_row;
          if ({1'b0, prime_row} < IMG_H_C) begin
            state_d  = RD_TOP;
            fx_d     = 10'd0;
            fy_d     = prime_row;
            prime_d  = 1'b1;
            win_d[0] = '0;
            win_d[1] = '0;
          end
        end else begin
          zpend_d = 1'b1;
        end
      end
      RD_TOP: begin
        state_d     = RD_MID;
        win_d[2][0] = rd_val;
      end
      RD_MID: begin
        state_d     = RD_BOT;
        win_d[2][1] = rd_val;
      end
      default: begin
        state_d     = IDLE;
        win_d[2][2] = rd_val;
        gray_d      = prime_q ? 4'd0 : out_res;
      end
    endcase

    // read issued for the slot being entered
    case (state_d)
      RD_MID:  slot = 2'd1;
      RD_BOT:  slot = 2'd2;
      default: slot = 2'd0;
    endcase
    row_p1  = {1'b0, fy_d} + {9'd0, slot};
    rd_en_d = (state_d != IDLE) && (row_p1 != 11'd0) && (row_p1 <= IMG_H_C) && (fx_d < IMG_W_C);
    addr_d  = addr_q;
    if (rd_en_d)
      addr_d = ADDR_W'(row_p1 - 11'd1) * IMG_W_A + ADDR_W'(fx_d);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= IDLE;
      win_q        <= '0;
      fx_q         <= '0;
      fy_q         <= '0;
      kern_q       <= '0;
      prime_q      <= 1'b0;
      zpend_q      <= 1'b0;
      primed_vld_q <= 1'b0;
      primed_row_q <= '0;
      gray_q       <= '0;
      rd_en_q      <= 1'b0;
      addr_q       <= '0;
      overrun_q    <= 1'b0;
      sync_err_q   <= 1'b0;
`ifdef CONV_THRESHOLD_EN
      thr_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      win_q        <= win_d;
      fx_q         <= fx_d;
      fy_q         <= fy_d;
      kern_q       <= kern_d;
      prime_q      <= prime_d;
      zpend_q      <= zpend_d;
      primed_vld_q <= primed_vld_d;
      primed_row_q <= primed_row_d;
      gray_q       <= gray_d;
      rd_en_q      <= rd_en_d;
      addr_q       <= addr_d;
      overrun_q    <= overrun_d;
      sync_err_q   <= sync_err_d;
`ifdef CONV_THRESHOLD_EN
      thr_q        <= thr_d;
`endif
    end
  end

  assign mem_rd_en       = rd_en_q;
  assign mem_addr        = addr_q;
  assign grayscale_pixel = gray_q;
  assign busy            = (state_q != IDLE);
  assign overrun         = overrun_q;
  assign sync_err        = sync_err_q;
endmodule

// File: tb/tb_conv3x3_pixel_source.sv
`timescale 1ns/1ps
module tb_conv3x3_pixel_source;
  localparam int W = 640;
  localparam int H = 480;

  logic        clk = 1'b0, reset = 1'b0, pixel_request = 1'b0;
  logic [9:0]  pixel_x = '0, pixel_y = '0;
  logic [1:0]  kernel_sel = '0;
  logic        mem_rd_en;
  logic [18:0] mem_addr;
  logic [3:0]  mem_rd_data = '0;
  logic [3:0]  grayscale_pixel;
  logic        busy, overrun, sync_err;
  logic [3:0]  thr_now;
`ifdef CONV_THRESHOLD_EN
  logic [3:0]  threshold = 4'd8;
  assign thr_now = threshold;
`else
  assign thr_now = 4'd0;
`endif

  int n_cmp = 0, n_bad = 0;
  logic [3:0] mem [0:W*H-1];

  always #5 clk = ~clk;

  conv3x3_pixel_source dut (
    .clk(clk), .reset(reset), .pixel_request(pixel_request),
    .pixel_x(pixel_x), .pixel_y(pixel_y), .kernel_sel(kernel_sel),
`ifdef CONV_THRESHOLD_EN
    .threshold(threshold),
`endif
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rd_data(mem_rd_data),
    .grayscale_pixel(grayscale_pixel), .busy(busy), .overrun(overrun), .sync_err(sync_err)
  );

  // frame memory: address seen during a cycle is answered for the next edge
  always @(negedge clk) if (mem_rd_en) mem_rd_data <= mem[mem_addr];

  // ---------------- behavioural model ----------------
  int  cyc = 0;
  int  busy_last = -100, f_start = -100;
  int  f_addr [3];
  bit  f_ok [3];
  int  g_cyc = -1, g_val = 0;
  bit  exp_ovr = 0, exp_serr = 0, pvalid = 0;
  int  prow = 0;
  int  wcol [3], wrow [3];
  bit  wz [3] = '{1, 1, 1};
  int  mx, my, mp;

  function automatic int pix(int r, int c);
    if (r < 0 || r >= H || c < 0 || c >= W) return 0;
    return int'(mem[r*W + c]);
  endfunction

  function automatic int conv(int k, int th);
    int g [3][3];
    int sum, c, n4, v;
    sum = 0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++) begin
        g[i][j] = wz[i] ? 0 : pix(wrow[i] + j - 1, wcol[i]);
        sum += g[i][j];
      end
    c  = g[1][1];
    n4 = g[1][0] + g[1][2] + g[0][1] + g[2][1];
    case (k)
      0: v = c;
      1: v = (sum * 57) / 512;
      2: begin v = 8*c - (sum - c); if (v < 0) v = -v; if (v > 15) v = 15; end
      default: begin v = 5*c - n4; if (v < 0) v = 0; if (v > 15) v = 15; end
    endcase
`ifdef CONV_THRESHOLD_EN
    v = (v >= th) ? 15 : 0;
`endif
    return v;
  endfunction

  task automatic start_fetch(int col, int y);
    f_start = cyc;
    busy_last = cyc + 2;
    for (int k = 0; k < 3; k++) begin
      f_ok[k]   = (y + k - 1 >= 0) && (y + k - 1 < H) && (col < W);
      f_addr[k] = (y + k - 1) * W + col;
    end
  endtask

  always @(posedge clk) begin
    cyc++;
    if (!reset) begin
      busy_last = -100; f_start = -100; g_cyc = cyc; g_val = 0;
      exp_ovr = 0; exp_serr = 0; pvalid = 0;
      for (int i = 0; i < 3; i++) wz[i] = 1;
    end else if (pixel_request) begin
      mx = int'(pixel_x); my = int'(pixel_y);
      if (cyc <= busy_last + 1) exp_ovr = 1;
      else if (mx < W && my < H) begin
        if (mx == 0 && !(pvalid && prow == my)) begin
          exp_serr = 1; g_cyc = cyc + 1; g_val = 0;
        end else begin
          wcol[0] = wcol[1]; wrow[0] = wrow[1]; wz[0] = wz[1];
          wcol[1] = wcol[2]; wrow[1] = wrow[2]; wz[1] = wz[2];
          wcol[2] = mx + 1;  wrow[2] = my;      wz[2] = 0;
          start_fetch(mx + 1, my);
          g_cyc = cyc + 3; g_val = conv(int'(kernel_sel), int'(thr_now));
        end
      end else if (mx == 799) begin
        mp = (my == 524) ? 0 : my + 1;
        pvalid = 1; prow = mp;
        if (mp < H) begin
          wz[0] = 1; wz[1] = 1; wcol[2] = 0; wrow[2] = mp; wz[2] = 0;
          start_fetch(0, mp);
          g_cyc = cyc + 3; g_val = 0;
        end
      end else begin
        g_cyc = cyc + 1; g_val = 0;
      end
    end
  end

  // ---------------- single compare process ----------------
  int    exp_gray = 0;
  bit    exp_rd;
  bit    pin_go = 0;
  int    pin_kind = 0, pin_lit = 0;
  string pin_nm = "";

  task automatic check(string nm, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s cycle %0d: got %0d expected %0d", nm, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (cyc == g_cyc) exp_gray = g_val;
    if (cyc > 0) begin
      exp_rd = (cyc >= f_start && cyc <= f_start + 2) ? f_ok[cyc - f_start] : 1'b0;
      check("gray", int'(grayscale_pixel), exp_gray);
      check("busy", int'(busy), int'(cyc <= busy_last));
      check("rd_en", int'(mem_rd_en), int'(exp_rd));
      if (exp_rd) check("addr", int'(mem_addr), f_addr[cyc - f_start]);
      check("overrun", int'(overrun), int'(exp_ovr));
      check("sync_err", int'(sync_err), int'(exp_serr));
      if (pin_go) begin
        case (pin_kind)
          0: begin
            check(pin_nm, int'(grayscale_pixel), pin_lit);
            check({pin_nm, "_model"}, exp_gray, pin_lit);
          end
          1: begin
            check(pin_nm, int'(overrun), pin_lit);
            check({pin_nm, "_model"}, int'(exp_ovr), pin_lit);
          end
          default: begin
            check(pin_nm, int'(sync_err), pin_lit);
            check({pin_nm, "_model"}, int'(exp_serr), pin_lit);
          end
        endcase
      end
    end
  end

  // ---------------- stimulus ----------------
  function automatic int lit(int v);
`ifdef CONV_THRESHOLD_EN
    return (v >= 8) ? 15 : 0;
`else
    return v;
`endif
  endfunction

  task automatic req(input int x, input int y, input int k);
    @(negedge clk);
    pixel_request = 1'b1; pixel_x = 10'(x); pixel_y = 10'(y); kernel_sel = 2'(k);
    @(negedge clk);
    pixel_request = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic pin(input string nm, input int kind, input int v);
    #1;
    pin_nm = nm; pin_kind = kind; pin_lit = v; pin_go = 1'b1;
    @(negedge clk);
    #1 pin_go = 1'b0;
  endtask

  // prime row y, then walk x = 0..xlast with identity, last request uses klast
  task automatic row_run(input int y, input int xlast, input int klast);
    req(799, (y == 0) ? 524 : y - 1, 0);
    for (int x = 0; x <= xlast; x++) req(x, y, (x == xlast) ? klast : 0);
  endtask

  initial begin
    for (int i = 0; i < W*H; i++) mem[i] = 4'd9;
    mem[20*W + 10] = 4'd10;
    mem[19*W + 10] = 4'd15; mem[21*W + 10] = 4'd15;
    mem[20*W + 9]  = 4'd15; mem[20*W + 11] = 4'd15;
    mem[40*W + 30] = 4'd15;
    mem[39*W + 30] = 4'd0;  mem[41*W + 30] = 4'd0;
    mem[40*W + 29] = 4'd0;  mem[40*W + 31] = 4'd0;
    mem[50*W + 0]  = 4'd7;  mem[50*W + 1]  = 4'd8;

    repeat (3) @(negedge clk);
    reset = 1'b1;
    pin("reset_gray", 0, 0);
    pin("reset_overrun", 1, 0);
    pin("reset_sync_err", 2, 0);

    // identity along row 0 after a prime of row 0
    req(799, 524, 0);
    for (int x = 0; x < 4; x++) begin
      req(x, 0, 0);
      pin("ident_row0", 0, lit(9));
    end

    req(799, 524, 0);
    req(0, 0, 2);
    pin("lap_corner", 0, lit(15));

    row_run(5, 5, 2);
    pin("lap_flat", 0, lit(0));
    row_run(5, 5, 1);
    pin("box_flat", 0, lit(9));

    row_run(20, 10, 3);
    pin("sharpen_neg", 0, lit(0));
    row_run(40, 30, 3);
    pin("sharpen_sat", 0, lit(15));

    req(700, 10, 0);
    pin("out_of_image", 0, 0);

    row_run(50, 0, 0);
    pin("pixel7", 0, lit(7));
    req(1, 50, 0);
    pin("pixel8", 0, lit(8));

    row_run(10, 2, 0);
    pin("ident_row10", 0, lit(9));
    req(799, 479, 0);
    pin("prime_past_bottom", 0, lit(9));
    req(0, 10, 0);
    pin("unprimed_x0_gray", 0, 0);
    pin("unprimed_x0_flag", 2, 1);

    // second request two cycles after an accepted one
    @(negedge clk);
    pixel_request = 1'b1; pixel_x = 10'd3; pixel_y = 10'd10; kernel_sel = 2'd0;
    @(negedge clk); pixel_request = 1'b0;
    @(negedge clk); pixel_request = 1'b1; pixel_x = 10'd4;
    @(negedge clk); pixel_request = 1'b0;
    repeat (4) @(negedge clk);
    pin("overrun_set", 1, 1);
    req(4, 10, 0);
    pin("overrun_sticky", 1, 1);

    // reset held low for two edges in the middle of a fetch
    @(negedge clk);
    pixel_request = 1'b1; pixel_x = 10'd4; pixel_y = 10'd0; kernel_sel = 2'd0;
    @(negedge clk); pixel_request = 1'b0; reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    pin("midfetch_gray", 0, 0);
    pin("midfetch_overrun", 1, 0);
    pin("midfetch_sync_err", 2, 0);
    // zeroed L/C columns: centre 0, neighbours 9+9 -> 18 -> 15
    req(3, 0, 2);
    pin("window_cleared", 0, lit(15));

    repeat (5) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
